// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the PC / instruction-fetch controller.
//   state_e    : controller FSM states
//   pc_sel_e   : next-PC source chosen by the priority mux
//   ALIGN_MASK : low PC bits that must be zero for a word-aligned fetch
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SEL_PC4  = 2'd0,
    SEL_BR   = 2'd1,
    SEL_JMP  = 2'd2,
    SEL_HOLD = 2'd3
  } pc_sel_e;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: halt > stall > jump > branch_taken > pc_plus4.
// Ports:
//   pc, pc_plus4, branch_target : candidate addresses
//   jump_index                  : J-type index, combined with pc_plus4[31:28]
//   halt, stall, jump, branch_taken : EXEC control inputs
//   sel     : which source won (SEL_HOLD for halt or stall)
//   next_pc : selected address (current pc when holding)
module pc_next_sel
  import pc_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] branch_target,
  input  logic [25:0] jump_index,
  input  logic        halt,
  input  logic        stall,
  input  logic        jump,
  input  logic        branch_taken,
  output pc_sel_e     sel,
  output logic [31:0] next_pc
);

  logic [31:0] jump_addr;

  // Jump stays within the 256 MB region of the following instruction.
  assign jump_addr = {pc_plus4[31:28], jump_index, 2'b00};

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    sel     = SEL_PC4;
    next_pc = pc_plus4;
    if (halt || stall) begin
      sel     = SEL_HOLD;
      next_pc = pc;
    end else if (jump) begin
      sel     = SEL_JMP;
      next_pc = jump_addr;
    end else if (branch_taken) begin
      sel     = SEL_BR;
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC and instruction-fetch controller.
// Sequences IDLE -> FETCH -> EXEC -> FETCH ..., with HALTED as a terminal
// state left only through reset.
// Ports:
//   clk, reset_n                 : clock, asynchronous active-low reset
//   pc_plus4, branch_target      : candidate next PCs from upstream adders
//   branch_taken, jump, jump_index, stall, halt : EXEC controls
//   imem_ack, imem_rdata         : instruction memory response
//   pc, imem_req, imem_addr      : current PC and fetch request
//   instr, instr_valid           : latched instruction, valid in EXEC
//   halted, misaligned           : HALTED indicator, sticky alignment error
//   retire_count                 : retired-instruction counter (wraps)
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic        ALIGN_CHECK  = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] branch_target,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        stall,
  input  logic        halt,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        halted,
  output logic        misaligned,
  output logic [31:0] retire_count
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] retire_q, retire_d;

  pc_sel_e     sel;
  logic [31:0] next_pc;
  logic        bad_align;

  pc_next_sel u_next_sel (
    .pc            (pc_q),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target),
    .jump_index    (jump_index),
    .halt          (halt),
    .stall         (stall),
    .jump          (jump),
    .branch_taken  (branch_taken),
    .sel           (sel),
    .next_pc       (next_pc)
  );

  assign bad_align = ALIGN_CHECK && ((next_pc[1:0] & ALIGN_MASK) != 2'b00);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    misaligned_d = misaligned_q;
    retire_d     = retire_q;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (sel == SEL_HOLD) begin
          // Stall simply stays here; halt retires nothing and stops.
          if (halt) state_d = ST_HALTED;
        end else if (bad_align) begin
          misaligned_d = 1'b1;
          state_d      = ST_HALTED;
        end else begin
          pc_d     = next_pc;
          retire_d = retire_q + 32'd1;
          state_d  = ST_FETCH;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_VECTOR;
      instr_q      <= 32'd0;
      misaligned_q <= 1'b0;
      retire_q     <= 32'd0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      misaligned_q <= misaligned_d;
      retire_q     <= retire_d;
    end
  end

  // Decoded from the state register so reset drops imem_req at once.
  assign imem_req     = (state_q == ST_FETCH);
  assign instr_valid  = (state_q == ST_EXEC);
  assign halted       = (state_q == ST_HALTED);
  assign pc           = pc_q;
  assign imem_addr    = pc_q;
  assign instr        = instr_q;
  assign misaligned   = misaligned_q;
  assign retire_count = retire_q;

endmodule
